seg_scan_ctrl: RTL and testbench

// Time-multiplexed scan controller for NUM_DIGITS common-anode 7-segment digits sharing one bcd7seg decoder.

---
 rtl/seg_scan_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed scan controller for NUM_DIGITS common-anode
//               7-segment digits sharing a single bcd7seg decoder. Sequences
//               digit slots with anti-ghost blanking, optional leading-zero
//               suppression and frame-synchronous display updates.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic                      lz_en,
    output logic [3:0]                bcd_out,
    output logic [NUM_DIGITS-1:0]     an_n,
    output logic                      frame_done,
    output logic                      upd_pending
);

    localparam int C_MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int C_CW   = (C_MAXC > 1) ? $clog2(C_MAXC) : 1;
    localparam int C_IW   = $clog2(NUM_DIGITS);

    localparam logic [C_CW-1:0] C_SHOW_LAST  = C_CW'(REFRESH_DIV - 1);
    localparam logic [C_CW-1:0] C_BLANK_LAST = C_CW'(BLANK_CYCLES - 1);
    localparam logic [C_IW-1:0] C_IDX_LAST   = C_IW'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [C_IW-1:0]           r_idx, w_idx_nxt;
    logic [C_CW-1:0]           r_cnt, w_cnt_nxt;
    logic                      w_frame_end;

    logic [4*NUM_DIGITS-1:0]   r_act_data, w_act_data_nxt;
    logic [NUM_DIGITS-1:0]     r_act_en, w_act_en_nxt;
    logic                      r_act_lz, w_act_lz_nxt;
    logic [4*NUM_DIGITS-1:0]   r_pend_data;
    logic [NUM_DIGITS-1:0]     r_pend_en;
    logic                      r_pend_lz;
    logic                      r_upd_pending, w_upd_pending_nxt;

    logic                      w_zero_run;
    logic [NUM_DIGITS-1:0]     w_supp;
    logic [3:0]                w_digit;
    logic                      w_vis;
    logic [NUM_DIGITS-1:0]     w_an_nxt;
    logic [3:0]                w_bcd_nxt;
    logic                      w_fd_nxt;

    logic [3:0]                r_bcd;
    logic [NUM_DIGITS-1:0]     r_an_n;
    logic                      r_frame_done;

    // Last lit cycle of the top digit; the commit point for pending config.
    assign w_frame_end = (r_state == ST_SHOW) && (r_idx == C_IDX_LAST) && (r_cnt == C_SHOW_LAST);

    // Scan FSM state register: state, digit index and per-state cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BLANK;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: counter restarts on every state change.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt + C_CW'(1);
        case (r_state)
            ST_BLANK: begin
                if (r_cnt == C_BLANK_LAST) begin
                    w_state_nxt = ST_SHOW;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SHOW: begin
                if (r_cnt == C_SHOW_LAST) begin
                    w_state_nxt = ST_BLANK;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = (r_idx == C_IDX_LAST) ? '0 : r_idx + C_IW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Config update: a load in the frame-end cycle bypasses pending straight to active.
    always_comb begin
        w_act_data_nxt    = r_act_data;
        w_act_en_nxt      = r_act_en;
        w_act_lz_nxt      = r_act_lz;
        w_upd_pending_nxt = r_upd_pending;
        if (w_frame_end && load) begin
            w_act_data_nxt    = data_in;
            w_act_en_nxt      = digit_en;
            w_act_lz_nxt      = lz_en;
            w_upd_pending_nxt = 1'b0;
        end else if (w_frame_end && r_upd_pending) begin
            w_act_data_nxt    = r_pend_data;
            w_act_en_nxt      = r_pend_en;
            w_act_lz_nxt      = r_pend_lz;
            w_upd_pending_nxt = 1'b0;
        end else if (load) begin
            w_upd_pending_nxt = 1'b1;
        end
    end

    // Active and pending configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_data    <= '0;
            r_act_en      <= '1;
            r_act_lz      <= 1'b0;
            r_pend_data   <= '0;
            r_pend_en     <= '1;
            r_pend_lz     <= 1'b0;
            r_upd_pending <= 1'b0;
        end else begin
            r_act_data    <= w_act_data_nxt;
            r_act_en      <= w_act_en_nxt;
            r_act_lz      <= w_act_lz_nxt;
            r_upd_pending <= w_upd_pending_nxt;
            if (load) begin
                r_pend_data <= data_in;
                r_pend_en   <= digit_en;
                r_pend_lz   <= lz_en;
            end
        end
    end

    // Leading-zero mask: walk down from the top digit while every digit seen is zero.
    always_comb begin
        w_zero_run = 1'b1;
        w_supp     = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run && (w_act_data_nxt[4*k +: 4] == 4'd0);
            w_supp[k]  = w_act_lz_nxt && w_zero_run && (k != 0);
        end
    end

    // Output decode from next state so the registered outputs line up with the FSM.
    always_comb begin
        w_digit = 4'hF;
        w_vis   = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k == int'(w_idx_nxt)) begin
                w_digit = w_act_data_nxt[4*k +: 4];
                w_vis   = w_act_en_nxt[k] && !w_supp[k];
            end
        end
        w_an_nxt  = '1;
        w_bcd_nxt = 4'hF;
        if ((w_state_nxt == ST_SHOW) && w_vis) begin
            w_bcd_nxt = w_digit;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (k == int'(w_idx_nxt)) begin
                    w_an_nxt[k] = 1'b0;
                end
            end
        end
        w_fd_nxt = (w_state_nxt == ST_SHOW) && (w_idx_nxt == C_IDX_LAST) &&
                   (w_cnt_nxt == C_SHOW_LAST);
    end

    // Registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_n       <= '1;
            r_bcd        <= 4'hF;
            r_frame_done <= 1'b0;
        end else begin
            r_an_n       <= w_an_nxt;
            r_bcd        <= w_bcd_nxt;
            r_frame_done <= w_fd_nxt;
        end
    end

    assign an_n        = r_an_n;
    assign bcd_out     = r_bcd;
    assign frame_done  = r_frame_done;
    assign upd_pending = r_upd_pending;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Self-checking bench for seg_scan_ctrl (4 digits, 4-cycle
//               refresh, 1-cycle blanking) against a position-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int R     = 4;
    localparam int B     = 1;
    localparam int SLOT  = R + B;
    localparam int FRAME = N * SLOT;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [15:0]   data_in;
    logic [3:0]    digit_en;
    logic          lz_en;
    logic [3:0]    bcd_out;
    logic [3:0]    an_n;
    logic          frame_done;
    logic          upd_pending;

    int            n_checks;
    int            n_fail;

    // Model state: cycle position since reset plus active/pending config.
    int            p;
    logic [15:0]   m_data, q_data;
    logic [3:0]    m_en, q_en;
    logic          m_lz, q_lz, m_pend;
    logic [8:0]    exp_o;

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .BLANK_CYCLES (B)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .data_in     (data_in),
        .digit_en    (digit_en),
        .lz_en       (lz_en),
        .bcd_out     (bcd_out),
        .an_n        (an_n),
        .frame_done  (frame_done),
        .upd_pending (upd_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {an_n, bcd, frame_done} for a given position in the scan.
    function automatic logic [8:0] model_out(input int pos, input logic [15:0] d,
                                             input logic [3:0] en, input logic lz);
        int   slot;
        int   ph;
        logic fd;
        logic hidden;
        logic [15:0] dd;
        slot   = (pos / SLOT) % N;
        ph     = pos % SLOT;
        fd     = (slot == N - 1) && (ph == SLOT - 1);
        dd     = d >> (4 * slot);
        hidden = (ph < B) || !en[slot] || (lz && slot != 0 && dd == 16'd0);
        if (hidden)
            return {4'hF, 4'hF, fd};
        return {~(4'b0001 << slot), dd[3:0], fd};
    endfunction

    task automatic model_reset();
        p      = 0;
        m_data = 16'h0000;
        m_en   = 4'hF;
        m_lz   = 1'b0;
        m_pend = 1'b0;
    endtask

    // One clock with given inputs; the model advances using the pre-edge position.
    task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] en,
                        input logic lz);
        load     = ld;
        data_in  = d;
        digit_en = en;
        lz_en    = lz;
        @(posedge clk);
        if (p % FRAME == FRAME - 1) begin
            if (ld) begin
                m_data = d; m_en = en; m_lz = lz;
            end else if (m_pend) begin
                m_data = q_data; m_en = q_en; m_lz = q_lz;
            end
            m_pend = 1'b0;
        end else if (ld) begin
            q_data = d; q_en = en; q_lz = lz;
            m_pend = 1'b1;
        end
        p++;
        #1;
        load = 1'b0;
        exp_o = model_out(p, m_data, m_en, m_lz);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; data_in = '0; digit_en = 4'hF; lz_en = 1'b0;
        model_reset();
        #22;
        n_checks++;
        if ({an_n, bcd_out, frame_done, upd_pending} !== {4'hF, 4'hF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset an_n=%b bcd=%h fd=%b pend=%b required 1111/f/0/0",
                     an_n, bcd_out, frame_done, upd_pending);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({an_n, bcd_out} !== {4'hF, 4'hF}) begin
            n_fail++;
            $display("FAIL reset_release an_n=%b bcd=%h required 1111/f", an_n, bcd_out);
        end
    endtask

    task automatic test_power_up();
        int fd_count;
        fd_count = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, data_in, digit_en, lz_en);
            fd_count += int'(frame_done);
            n_checks++;
            if ({an_n, bcd_out, frame_done, upd_pending} !== {exp_o, m_pend}) begin
                n_fail++;
                $display("FAIL power_up p=%0d got an_n=%b bcd=%h fd=%b pend=%b exp an_n=%b bcd=%h fd=%b pend=%b",
                         p, an_n, bcd_out, frame_done, upd_pending, exp_o[8:5], exp_o[4:1], exp_o[0], m_pend);
            end
        end
        n_checks++;
        if (fd_count != 2) begin
            n_fail++;
            $display("FAIL frame_done_count got %0d required 2", fd_count);
        end
    endtask

    // Load mid-frame, then run until the new data has been shown for a full frame.
    task automatic run_load(input string name, input logic [15:0] d, input logic [3:0] en,
                            input logic lz);
        for (int i = 0; i < 7; i++) step(1'b0, data_in, digit_en, lz_en);
        step(1'b1, d, en, lz);
        n_checks++;
        if (upd_pending !== m_pend) begin
            n_fail++;
            $display("FAIL %s_pending got %b required %b", name, upd_pending, m_pend);
        end
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, data_in, digit_en, lz_en);
            n_checks++;
            if ({an_n, bcd_out, frame_done, upd_pending} !== {exp_o, m_pend}) begin
                n_fail++;
                $display("FAIL %s p=%0d got an_n=%b bcd=%h fd=%b pend=%b exp an_n=%b bcd=%h fd=%b pend=%b",
                         name, p, an_n, bcd_out, frame_done, upd_pending, exp_o[8:5], exp_o[4:1], exp_o[0], m_pend);
            end
        end
    endtask

    task automatic test_load_commit();
        run_load("load_1234", 16'h1234, 4'hF, 1'b0);
    endtask

    task automatic test_leading_zero();
        run_load("lz_0070", 16'h0070, 4'hF, 1'b1);
        run_load("lz_0000", 16'h0000, 4'hF, 1'b1);
    endtask

    task automatic test_digit_en();
        run_load("en_9999", 16'h9999, 4'b0101, 1'b0);
        run_load("code_00a0", 16'h00A0, 4'hF, 1'b1);
    endtask

    task automatic test_same_cycle();
        step(1'b1, 16'h1111, 4'hF, 1'b0);
        for (int i = 0; i < FRAME && (p % FRAME) != FRAME - 1; i++)
            step(1'b0, data_in, digit_en, lz_en);
        n_checks++;
        if (frame_done !== 1'b1 || upd_pending !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_setup fd=%b pend=%b required 1/1", frame_done, upd_pending);
        end
        step(1'b1, 16'h5555, 4'hF, 1'b0);
        for (int i = 0; i < FRAME; i++) begin
            n_checks++;
            if ({an_n, bcd_out, frame_done, upd_pending} !== {exp_o, m_pend}) begin
                n_fail++;
                $display("FAIL same_cycle p=%0d got an_n=%b bcd=%h fd=%b pend=%b exp an_n=%b bcd=%h fd=%b pend=%b",
                         p, an_n, bcd_out, frame_done, upd_pending, exp_o[8:5], exp_o[4:1], exp_o[0], m_pend);
            end
            step(1'b0, data_in, digit_en, lz_en);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) == 0), 16'($urandom), 4'($urandom), 1'($urandom));
            n_checks++;
            if ({an_n, bcd_out, frame_done, upd_pending} !== {exp_o, m_pend} ||
                $countones(~an_n) > 1) begin
                n_fail++;
                $display("FAIL random p=%0d got an_n=%b bcd=%h fd=%b pend=%b exp an_n=%b bcd=%h fd=%b pend=%b",
                         p, an_n, bcd_out, frame_done, upd_pending, exp_o[8:5], exp_o[4:1], exp_o[0], m_pend);
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 16'h8765, 4'hF, 1'b0);
        for (int i = 0; i < FRAME && (p % FRAME) != 2 * SLOT + 2; i++)
            step(1'b0, data_in, digit_en, lz_en);
        step(1'b1, 16'h4321, 4'hF, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({an_n, bcd_out, frame_done, upd_pending} !== {4'hF, 4'hF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset an_n=%b bcd=%h fd=%b pend=%b required 1111/f/0/0",
                     an_n, bcd_out, frame_done, upd_pending);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, data_in, digit_en, lz_en);
            n_checks++;
            if ({an_n, bcd_out, frame_done, upd_pending} !== {exp_o, m_pend}) begin
                n_fail++;
                $display("FAIL after_reset p=%0d got an_n=%b bcd=%h fd=%b pend=%b exp an_n=%b bcd=%h fd=%b pend=%b",
                         p, an_n, bcd_out, frame_done, upd_pending, exp_o[8:5], exp_o[4:1], exp_o[0], m_pend);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        q_data   = '0;
        q_en     = 4'hF;
        q_lz     = 1'b0;
        exp_o    = '0;
        test_reset();
        test_power_up();
        test_load_commit();
        test_leading_zero();
        test_digit_en();
        test_same_cycle();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
